btb_update_queue: RTL



---
 rtl/Falco_pkg.sv | 19 +
 rtl/btb_update_queue_fifo_2w1r.sv | 43 ++++
 rtl/btb_update_queue.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/Falco_pkg.sv
// Falco_pkg: core-wide types shared by the fetch and execute stages.
//   XLEN_WIDTH     : machine word / PC width.
//   pc_t           : program counter type.
//   BTB_UPDQ_DEPTH : default FIFO depth of the BTB update queue.
//   btb_update_t   : one BTB write (branch PC and its resolved target).
package Falco_pkg;

  localparam int XLEN_WIDTH = 32;

  typedef logic [XLEN_WIDTH-1:0] pc_t;

  localparam int BTB_UPDQ_DEPTH = 8;

  typedef struct packed {
    pc_t addr;
    pc_t target;
  } btb_update_t;

endpackage

// File: rtl/btb_update_queue_fifo_2w1r.sv
// fifo_2w1r: storage array for BTB updates with two ordered write ports
// and one asynchronous read port. Pointer and occupancy bookkeeping live in
// the instantiating module; this block only holds the data.
//   clk      : core clock.
//   wr_en0   : write wr_data0 at wr_ptr.
//   wr_en1   : write wr_data1 at wr_ptr+1 (only meaningful with wr_en0).
//   wr_ptr   : write index of the older entry.
//   wr_data0 : older entry.
//   wr_data1 : younger entry.
//   rd_ptr   : read index.
//   rd_data  : entry at rd_ptr (combinational).
module fifo_2w1r
  import Falco_pkg::*;
#(
  parameter int DEPTH = BTB_UPDQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en0,
  input  logic              wr_en1,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  btb_update_t       wr_data0,
  input  btb_update_t       wr_data1,
  input  logic [PTR_W-1:0]  rd_ptr,
  output btb_update_t       rd_data
);

  btb_update_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_inc;

  // Wraps modulo DEPTH because DEPTH is a power of two.
  assign wr_ptr_inc = wr_ptr + PTR_W'(1);

  // NOTE: storage is deliberately not reset; only the pointers and count
  // define which entries are valid, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (wr_en0) mem[wr_ptr]     <= wr_data0;
    if (wr_en1) mem[wr_ptr_inc] <= wr_data1;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/btb_update_queue.sv
// btb_update_queue: collects resolved branches from both EXE slots, keeps
// the taken ones, buffers them and drives the BTB's single write port with
// at most one update per cycle.
//   clk                 : core clock.
//   rst                 : synchronous, active-low reset.
//   br{0,1}_valid       : slot resolved a branch this cycle.
//   br{0,1}_taken       : that branch was taken.
//   br{0,1}_addr        : branch PC.
//   br{0,1}_target_addr : resolved target.
//   branch_valid        : registered BTB write strobe.
//   branch_taken        : mirror of branch_valid for the BTB port.
//   branch_addr         : registered update PC.
//   branch_target_addr  : registered update target.
//   queue_full          : registered, FIFO holds DEPTH entries.
//   drop_count          : saturating count of discarded updates.
module btb_update_queue
  import Falco_pkg::*;
#(
  parameter int DEPTH          = BTB_UPDQ_DEPTH,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      br0_valid,
  input  logic                      br0_taken,
  input  pc_t                       br0_addr,
  input  pc_t                       br0_target_addr,
  input  logic                      br1_valid,
  input  logic                      br1_taken,
  input  pc_t                       br1_addr,
  input  pc_t                       br1_target_addr,
  output logic                      branch_valid,
  output logic                      branch_taken,
  output pc_t                       branch_addr,
  output pc_t                       branch_target_addr,
  output logic                      queue_full,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W:0]          count;
  logic [PTR_W:0]          count_next;
  logic [PTR_W+1:0]        space;
  logic [DROP_CNT_WIDTH:0] drop_sum;

  btb_update_t upd0, upd1, first, q_first, head, out_data;

  logic       cand0, cand1, keep0;
  logic       fifo_empty, pop, bypass, out_load;
  logic       wr_en0, wr_en1;
  logic [1:0] n_cand, n_fifo, n_push, n_drop;

  assign upd0 = '{addr: br0_addr, target: br0_target_addr};
  assign upd1 = '{addr: br1_addr, target: br1_target_addr};

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    cand0      = br0_valid & br0_taken;
    cand1      = br1_valid & br1_taken;
    // Same PC in both slots: the younger slot-1 outcome supersedes slot 0.
    keep0      = cand0 & ~(cand1 && (br0_addr == br1_addr));
    n_cand     = {1'b0, keep0} + {1'b0, cand1};
    first      = keep0 ? upd0 : upd1;

    fifo_empty = (count == '0);
    pop        = !fifo_empty;
    bypass     = fifo_empty && (n_cand != 2'd0);

    // Candidates that must go through the FIFO, oldest first. On bypass the
    // oldest goes straight to the output register, so only slot 1 remains.
    n_fifo     = n_cand;
    q_first    = first;
    if (bypass) begin
      n_fifo  = n_cand - 2'd1;
      q_first = upd1;
    end

    // Popping frees a slot in the same cycle it is refilled.
    space      = (PTR_W+2)'(DEPTH) - (PTR_W+2)'(count) + (PTR_W+2)'(pop);
    wr_en0     = (n_fifo != 2'd0) && (space >= (PTR_W+2)'(1));
    wr_en1     = (n_fifo == 2'd2) && (space >= (PTR_W+2)'(2));
    n_push     = {1'b0, wr_en0} + {1'b0, wr_en1};
    n_drop     = n_fifo - n_push;

    out_load   = pop | bypass;
    out_data   = pop ? head : first;

    count_next = count + (PTR_W+1)'(n_push) - (PTR_W+1)'(pop);
    drop_sum   = {1'b0, drop_count} + (DROP_CNT_WIDTH+1)'(n_drop);
  end

  fifo_2w1r #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk      (clk),
    .wr_en0   (wr_en0),
    .wr_en1   (wr_en1),
    .wr_ptr   (wr_ptr),
    .wr_data0 (q_first),
    .wr_data1 (upd1),
    .rd_ptr   (rd_ptr),
    .rd_data  (head)
  );

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      queue_full <= 1'b0;
      drop_count <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(n_push);
      rd_ptr     <= rd_ptr + PTR_W'(pop);
      count      <= count_next;
      queue_full <= (count_next == (PTR_W+1)'(DEPTH));
      drop_count <= drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
    end
  end

  // Output register: never stalled, since the BTB accepts every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      branch_valid       <= 1'b0;
      branch_addr        <= '0;
      branch_target_addr <= '0;
    end else begin
      branch_valid <= out_load;
      if (out_load) begin
        branch_addr        <= out_data.addr;
        branch_target_addr <= out_data.target;
      end
    end
  end

  assign branch_taken = branch_valid;

endmodule
